// File: rtl/input_conditioner_if.sv
// CPU-side port of the front-panel input conditioner.
// rd is a one-cycle read strobe; status and irq come back.
interface input_conditioner_if;
    logic        rd;
    logic [31:0] status;
    logic        irq;

    modport master (output rd, input status, input irq);
    modport slave  (input rd, output status, output irq);
endinterface

// File: rtl/input_conditioner.sv
// Button debounce, quadrature decode and read-and-clear status word.
// Define INPUT_CONDITIONER_DETENT_EN to count one step per detent.
module input_conditioner #(
    parameter int BUTTONS         = 3,
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int DEBOUNCE_BITS   = 15,
    parameter int COUNT_BITS      = 8
) (
    input  logic               clk,
    input  logic               nreset,
    input  logic [BUTTONS-1:0] buttons_in,
    input  logic               tra,
    input  logic               trb,
    input_conditioner_if.slave bus
);
    localparam logic [DEBOUNCE_BITS-1:0] CNT_MAX =
        DEBOUNCE_BITS'(DEBOUNCE_CYCLES - 1);
    localparam logic [COUNT_BITS-1:0] D_MAX = {1'b0, {(COUNT_BITS-1){1'b1}}};
    localparam logic [COUNT_BITS-1:0] D_MIN = {1'b1, {(COUNT_BITS-1){1'b0}}};

    typedef enum logic [1:0] {FILL0, FILL1, PRIME, RUN} enc_st_e;

    logic [BUTTONS-1:0]       btn_s1_q, btn_s2_q;
    logic [1:0]               enc_s1_q, enc_s2_q;
    logic [BUTTONS-1:0]       cand_q, cand_d;
    logic [BUTTONS-1:0]       deb_q, deb_d;
    logic [DEBOUNCE_BITS-1:0] cnt_q [BUTTONS];
    logic [DEBOUNCE_BITS-1:0] cnt_d [BUTTONS];
    logic [BUTTONS-1:0]       press_q, press_d;
    logic [1:0]               prev_q, prev_d;
    enc_st_e                  st_q, st_d;
    logic [COUNT_BITS-1:0]    delta_q, delta_d;
    logic                     err_q, err_d;
    logic                     ovf_q, ovf_d;
    logic                     irq_q, irq_d;
    logic                     up, dn, bad;
    logic                     inc_up, inc_dn;

    // Debounced levels stay active-low (1 = released) internally
    always_comb begin
        cand_d = cand_q;
        deb_d  = deb_q;
        for (int i = 0; i < BUTTONS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (btn_s2_q[i] != cand_q[i]) begin
                cand_d[i] = btn_s2_q[i];
                cnt_d[i]  = '0;
            end else if (cnt_q[i] != CNT_MAX) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
            if (cnt_d[i] == CNT_MAX) deb_d[i] = cand_d[i];
        end
    end

    always_comb begin
        st_d = st_q;
        unique case (st_q)
            FILL0:   st_d = FILL1;
            FILL1:   st_d = PRIME;
            PRIME:   st_d = RUN;
            default: st_d = RUN;
        endcase
    end

    always_comb begin
        up     = 1'b0;
        dn     = 1'b0;
        bad    = 1'b0;
        prev_d = enc_s2_q;
        if (st_q == RUN && enc_s2_q != prev_q) begin
            if ((enc_s2_q ^ prev_q) == 2'b11) begin
                bad = 1'b1;
            end else begin
                unique case (prev_q)
                    2'b00:   up = (enc_s2_q == 2'b01);
                    2'b01:   up = (enc_s2_q == 2'b11);
                    2'b11:   up = (enc_s2_q == 2'b10);
                    default: up = (enc_s2_q == 2'b00);
                endcase
                dn = ~up;
            end
        end
    end

`ifdef INPUT_CONDITIONER_DETENT_EN
    // Sub-counter holds -3..+3; the fourth edge of a detent emits a step
    logic signed [2:0] sub_q, sub_d;

    always_comb begin
        sub_d  = sub_q;
        inc_up = 1'b0;
        inc_dn = 1'b0;
        if (up) begin
            if (sub_q == 3'sd3) begin
                inc_up = 1'b1;
                sub_d  = '0;
            end else begin
                sub_d = sub_q + 3'sd1;
            end
        end else if (dn) begin
            if (sub_q == -3'sd3) begin
                inc_dn = 1'b1;
                sub_d  = '0;
            end else begin
                sub_d = sub_q - 3'sd1;
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) sub_q <= '0;
        else         sub_q <= sub_d;
    end
`else
    assign inc_up = up;
    assign inc_dn = dn;
`endif

    // Events in the read cycle land on the freshly cleared state
    always_comb begin
        delta_d = bus.rd ? '0 : delta_q;
        ovf_d   = bus.rd ? 1'b0 : ovf_q;
        err_d   = (bus.rd ? 1'b0 : err_q) | bad;
        press_d = (bus.rd ? '0 : press_q) | (deb_q & ~deb_d);
        if (inc_up) begin
            if (delta_d == D_MAX) ovf_d = 1'b1;
            else                  delta_d = delta_d + 1'b1;
        end else if (inc_dn) begin
            if (delta_d == D_MIN) ovf_d = 1'b1;
            else                  delta_d = delta_d - 1'b1;
        end
        irq_d = (|delta_d) | (|press_d) | err_d | ovf_d;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            btn_s1_q <= '1;
            btn_s2_q <= '1;
            enc_s1_q <= '0;
            enc_s2_q <= '0;
            cand_q   <= '1;
            deb_q    <= '1;
            for (int i = 0; i < BUTTONS; i++) cnt_q[i] <= '0;
            press_q  <= '0;
            prev_q   <= '0;
            st_q     <= FILL0;
            delta_q  <= '0;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            btn_s1_q <= buttons_in;
            btn_s2_q <= btn_s1_q;
            enc_s1_q <= {tra, trb};
            enc_s2_q <= enc_s1_q;
            cand_q   <= cand_d;
            deb_q    <= deb_d;
            for (int i = 0; i < BUTTONS; i++) cnt_q[i] <= cnt_d[i];
            press_q  <= press_d;
            prev_q   <= prev_d;
            st_q     <= st_d;
            delta_q  <= delta_d;
            err_q    <= err_d;
            ovf_q    <= ovf_d;
            irq_q    <= irq_d;
        end
    end

    always_comb begin
        bus.status                   = '0;
        bus.status[COUNT_BITS-1:0]   = delta_q;
        bus.status[8 +: BUTTONS]     = ~deb_q;
        bus.status[16 +: BUTTONS]    = press_q;
        bus.status[29]               = err_q;
        bus.status[30]               = ovf_q;
        bus.status[31]               = irq_q;
    end

    assign bus.irq = irq_q;
endmodule
